scarv_cop_cprs_gen: RTL

SCARV_COP_CPRS_GEN -- requirements
Module: scarv_cop_cprs_gen

---
 rtl/scarv_cop_pkg.sv | 19 +
 rtl/scarv_cop_cprs_lane.sv | 60 ++++++
 rtl/scarv_cop_cprs_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the SCARV coprocessor register file.
// Holds the init-FSM state encoding and the legal parameter ranges
// that the register-file generator checks at elaboration.
package scarv_cop_pkg;

  // Init / clear sequencer states.
  typedef enum logic [1:0] {
    CPRS_IDLE  = 2'd0,
    CPRS_CLEAR = 2'd1,
    CPRS_DONE  = 2'd2
  } cprs_state_t;

  // Legal parameter ranges.
  localparam int CPRS_NREG_MIN = 2;
  localparam int CPRS_NREG_MAX = 64;
  localparam int CPRS_NRD_MIN  = 1;
  localparam int CPRS_NRD_MAX  = 4;

endpackage

// File: rtl/scarv_cop_cprs_lane.sv
// One byte lane of the register file: NREG x 8 bits, 1 write port,
// NRD combinational read ports, plus a clear port driven by the init FSM.
// Ports: i_clr_* clear one entry, i_wr_* byte write (pre-qualified by the
// top), i_rd_* packed read enables/addresses, o_rd_data packed read bytes.
module scarv_cop_cprs_lane #(
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int NRD    = 3,
  parameter int BYPASS = 0
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              i_clr_en,
  input  logic [AW-1:0]     i_clr_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [NRD-1:0]    i_rd_en,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD*8-1:0]  o_rd_data
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  // Contents are deliberately not reset; software clears via cprs_init.
  logic [7:0] r_mem [NREG];

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_L);
  endfunction

  // i_wr_en already excludes CLEAR and out-of-range addresses; reset still
  // wins over a write presented in the same cycle.
  always_ff @(posedge g_clk) begin
    if (i_clr_en) begin
      r_mem[i_clr_addr] <= 8'h00;
    end else if (i_wr_en && g_resetn) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  logic [AW-1:0] w_addr;

  always_comb begin
    o_rd_data = '0;
    w_addr    = '0;
    for (int p = 0; p < NRD; p++) begin
      w_addr = i_rd_addr[p*AW +: AW];
      if (i_rd_en[p] && in_range(w_addr)) begin
        // Forward the byte being written this cycle when enabled.
        if ((BYPASS != 0) && i_wr_en && (w_addr == i_wr_addr)) begin
          o_rd_data[p*8 +: 8] = i_wr_data;
        end else begin
          o_rd_data[p*8 +: 8] = r_mem[w_addr];
        end
      end
    end
  end

endmodule

// File: rtl/scarv_cop_cprs_gen.sv
// SCARV coprocessor register file: NREG x XLEN, NRD read ports, one
// byte-enabled write port, and an init FSM that clears every register.
// Ports: g_clk/g_resetn (sync, active-low), g_clk_req, cprs_init/_done,
// crs_* packed read ports, crd_* write port.
module scarv_cop_cprs_gen
  import scarv_cop_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int XLEN   = 32,
  parameter int NRD    = 3,
  parameter int BYPASS = 0
) (
  input  logic                              g_clk,
  input  logic                              g_resetn,
  output logic                              g_clk_req,
  input  logic                              cprs_init,
  output logic                              cprs_init_done,
  input  logic [NRD-1:0]                    crs_ren,
  input  logic [NRD*$clog2(NREG)-1:0]       crs_addr,
  output logic [NRD*XLEN-1:0]               crs_rdata,
  input  logic [XLEN/8-1:0]                 crd_wen,
  input  logic [$clog2(NREG)-1:0]           crd_addr,
  input  logic [XLEN-1:0]                   crd_wdata
);

  localparam int AW = $clog2(NREG);
  localparam int NB = XLEN / 8;
  localparam logic [AW:0]   NREG_L   = (AW+1)'(NREG);
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

  if (NREG < CPRS_NREG_MIN || NREG > CPRS_NREG_MAX ||
      NRD < CPRS_NRD_MIN || NRD > CPRS_NRD_MAX || (XLEN % 8) != 0) begin : g_bad_param
    $error("scarv_cop_cprs_gen: parameter out of range");
  end

  cprs_state_t   r_state;
  logic [AW-1:0] r_cnt;

  logic w_wr_ok;
  logic w_clr;

  // Writes (and forwarding) only outside CLEAR and only to real registers.
  assign w_wr_ok = ((r_state == CPRS_IDLE) || (r_state == CPRS_DONE)) &&
                   ({1'b0, crd_addr} < NREG_L);
  // A CLEAR edge with cprs_init low is an abort and clears nothing.
  assign w_clr   = (r_state == CPRS_CLEAR) && cprs_init && g_resetn;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state <= CPRS_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CPRS_IDLE: begin
          if (cprs_init) begin
            r_state <= CPRS_CLEAR;
            r_cnt   <= '0;
          end
        end
        CPRS_CLEAR: begin
          if (!cprs_init) begin
            r_state <= CPRS_IDLE;
          end else begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= CPRS_DONE;
            end
          end
        end
        CPRS_DONE: begin
          if (!cprs_init) begin
            r_state <= CPRS_IDLE;
          end
        end
        default: r_state <= CPRS_IDLE;
      endcase
    end
  end

  assign cprs_init_done = (r_state == CPRS_DONE);
  assign g_clk_req      = (|crd_wen) || (r_state != CPRS_IDLE) || cprs_init;

  logic [NRD*8-1:0] w_lane_rdata [NB];

  for (genvar b = 0; b < NB; b++) begin : g_lane
    scarv_cop_cprs_lane #(
      .NREG   (NREG),
      .AW     (AW),
      .NRD    (NRD),
      .BYPASS (BYPASS)
    ) u_lane (
      .g_clk      (g_clk),
      .g_resetn   (g_resetn),
      .i_clr_en   (w_clr),
      .i_clr_addr (r_cnt),
      .i_wr_en    (crd_wen[b] && w_wr_ok),
      .i_wr_addr  (crd_addr),
      .i_wr_data  (crd_wdata[b*8 +: 8]),
      .i_rd_en    (crs_ren),
      .i_rd_addr  (crs_addr),
      .o_rd_data  (w_lane_rdata[b])
    );
  end

  // Re-interleave lane outputs into per-port words.
  always_comb begin
    crs_rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int b = 0; b < NB; b++) begin
        crs_rdata[p*XLEN + b*8 +: 8] = w_lane_rdata[b][p*8 +: 8];
      end
    end
  end

endmodule
